// File: rtl/fetch_pc_pipe.sv
// fetch_pc_pipe: instruction-fetch stage of a 5-stage RISC-V pipeline.
// It holds the fetch PC, forms PC+4, selects the next PC (sequential or
// redirect target), and registers the fetched instruction and its PC
// values into the IF/ID pipeline register for decode.
module fetch_pc_pipe #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrcE,
    input  logic [WIDTH-1:0] PCTargetE,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D
);

    // Fetch PC register
    logic [WIDTH-1:0] r_pc;

    // IF/ID pipeline register contents
    logic [WIDTH-1:0] r_instr_d;
    logic [WIDTH-1:0] r_pc_d;
    logic [WIDTH-1:0] r_pc_plus4_d;

    // Sequential address and next-PC selection
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_pc_next;

    // PC+4 wraps modulo 2^WIDTH; the redirect target is taken as given,
    // with no alignment check.
    always_comb begin
        w_pc_plus4 = r_pc + WIDTH'(4);
        w_pc_next  = PCSrcE ? PCTargetE : w_pc_plus4;
    end

    // PC register: reset loads RESET_PC; a stall holds it and also drops
    // any redirect presented in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (!StallF) begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID register: flush clears to a bubble and takes priority over stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_d    <= '0;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
        end else if (FlushD) begin
            r_instr_d    <= '0;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
        end else if (!StallD) begin
            r_instr_d    <= InstrF;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
        end
    end

    assign PCF      = r_pc;
    assign PCPlus4F = w_pc_plus4;
    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pc_plus4_d;

endmodule

// File: tb/tb_fetch_pc_pipe.sv
// Testbench for fetch_pc_pipe: directed scenarios from the test plan plus a
// randomized run checked against a simple behavioural model of the fetch
// stage (a PC variable and a decode-slot record updated from the rules).
module tb_fetch_pc_pipe;

    logic        clk;
    logic        reset;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    int checks = 0;
    int errors = 0;

    // Instruction memory model: word at address a is a ^ salt.
    logic [31:0] salt = 32'h0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr_d;
    logic [31:0] m_pc_d;
    logic [31:0] m_pc4_d;

    fetch_pc_pipe #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .PCPlus4F  (PCPlus4F),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational external imem
    always_comb InstrF = PCF ^ salt;

    task automatic model_reset();
        m_pc      = 32'h0;
        m_instr_d = 32'h0;
        m_pc_d    = 32'h0;
        m_pc4_d   = 32'h0;
    endtask

    // Apply one cycle of inputs, clock once, advance the model, settle.
    task automatic step(input logic src, input logic [31:0] tgt,
                        input logic sf, input logic sd, input logic fl);
        PCSrcE    = src;
        PCTargetE = tgt;
        StallF    = sf;
        StallD    = sd;
        FlushD    = fl;
        @(posedge clk);
        if (fl) begin
            m_instr_d = 32'h0;
            m_pc_d    = 32'h0;
            m_pc4_d   = 32'h0;
        end else if (!sd) begin
            m_instr_d = m_pc ^ salt;
            m_pc_d    = m_pc;
            m_pc4_d   = m_pc + 32'd4;
        end
        if (!sf) m_pc = src ? tgt : m_pc + 32'd4;
        #1;
        $display("step src=%0b tgt=%h sf=%0b sd=%0b fl=%0b -> PCF=%h PCD=%h InstrD=%h PCPlus4D=%h",
                 src, tgt, sf, sd, fl, PCF, PCD, InstrD, PCPlus4D);
    endtask

    task automatic do_reset();
        PCSrcE = 0; PCTargetE = 0; StallF = 0; StallD = 0; FlushD = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        PCSrcE = 0; PCTargetE = 32'h1234_5678; StallF = 0; StallD = 0; FlushD = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got=%h exp=%h", PCF, 32'h0); end
        checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL reset_pc4f got=%h exp=%h", PCPlus4F, 32'h4); end
        checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL reset_instrd got=%h exp=%h", InstrD, 32'h0); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL reset_pcd got=%h exp=%h", PCD, 32'h0); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pc4d got=%h exp=%h", PCPlus4D, 32'h0); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_free_run();
        do_reset();
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL run_pcf0 got=%h exp=%h", PCF, 32'h0); end
        for (int i = 1; i <= 5; i++) begin
            step(0, 32'h0, 0, 0, 0);
            checks++; if (PCF !== 32'(4 * i)) begin errors++; $display("FAIL run_pcf[%0d] got=%h exp=%h", i, PCF, 32'(4 * i)); end
            checks++; if (PCD !== 32'(4 * (i - 1))) begin errors++; $display("FAIL run_pcd[%0d] got=%h exp=%h", i, PCD, 32'(4 * (i - 1))); end
            checks++; if (PCPlus4D !== 32'(4 * i)) begin errors++; $display("FAIL run_pc4d[%0d] got=%h exp=%h", i, PCPlus4D, 32'(4 * i)); end
            checks++; if (InstrD !== 32'(4 * (i - 1))) begin errors++; $display("FAIL run_instrd[%0d] got=%h exp=%h", i, InstrD, 32'(4 * (i - 1))); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL redir_pre_pcf got=%h exp=%h", PCF, 32'h8); end
        step(1, 32'h40, 0, 0, 0);
        checks++; if (PCF !== 32'h40) begin errors++; $display("FAIL redir_pcf got=%h exp=%h", PCF, 32'h40); end
        checks++; if (PCD !== 32'h8) begin errors++; $display("FAIL redir_pcd got=%h exp=%h", PCD, 32'h8); end
        step(0, 32'h0, 0, 0, 0);
        checks++; if (PCD !== 32'h40) begin errors++; $display("FAIL redir_pcd2 got=%h exp=%h", PCD, 32'h40); end
        checks++; if (PCPlus4D !== 32'h44) begin errors++; $display("FAIL redir_pc4d got=%h exp=%h", PCPlus4D, 32'h44); end
        checks++; if (InstrD !== 32'h40) begin errors++; $display("FAIL redir_instrd got=%h exp=%h", InstrD, 32'h40); end
        checks++; if (PCF !== 32'h44) begin errors++; $display("FAIL redir_pcf2 got=%h exp=%h", PCF, 32'h44); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) step(0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 32'h0, 1, 1, 0);
            checks++; if (PCF !== 32'hC) begin errors++; $display("FAIL stall_pcf[%0d] got=%h exp=%h", i, PCF, 32'hC); end
            checks++; if (PCD !== 32'h8) begin errors++; $display("FAIL stall_pcd[%0d] got=%h exp=%h", i, PCD, 32'h8); end
        end
        // Stall beats a simultaneous redirect: the target is dropped.
        step(1, 32'h80, 1, 0, 0);
        checks++; if (PCF !== 32'hC) begin errors++; $display("FAIL stall_redir_pcf got=%h exp=%h", PCF, 32'hC); end
        step(0, 32'h0, 0, 0, 0);
        checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL stall_resume_pcf got=%h exp=%h", PCF, 32'h10); end
        checks++; if (PCD !== 32'hC) begin errors++; $display("FAIL stall_resume_pcd got=%h exp=%h", PCD, 32'hC); end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (3) step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 1);
        checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL flush_instrd got=%h exp=%h", InstrD, 32'h0); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL flush_pcd got=%h exp=%h", PCD, 32'h0); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL flush_pc4d got=%h exp=%h", PCPlus4D, 32'h0); end
        checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL flush_pcf got=%h exp=%h", PCF, 32'h10); end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1, 32'hFFFF_FFFC, 0, 0, 0);
        checks++; if (PCF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcf got=%h exp=%h", PCF, 32'hFFFF_FFFC); end
        checks++; if (PCPlus4F !== 32'h0) begin errors++; $display("FAIL wrap_pc4f got=%h exp=%h", PCPlus4F, 32'h0); end
        step(0, 32'h0, 0, 0, 0);
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL wrap_pcf2 got=%h exp=%h", PCF, 32'h0); end
        checks++; if (PCD !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcd got=%h exp=%h", PCD, 32'hFFFF_FFFC); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap_pc4d got=%h exp=%h", PCPlus4D, 32'h0); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 32'h0, 0, 0, 0);
        step(1, 32'h40, 0, 0, 0);
        checks++; if (PCF !== 32'h40) begin errors++; $display("FAIL areset_pre_pcf got=%h exp=%h", PCF, 32'h40); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL areset_pcf got=%h exp=%h", PCF, 32'h0); end
        checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL areset_pc4f got=%h exp=%h", PCPlus4F, 32'h4); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL areset_pcd got=%h exp=%h", PCD, 32'h0); end
        checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL areset_instrd got=%h exp=%h", InstrD, 32'h0); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL areset_pc4d got=%h exp=%h", PCPlus4D, 32'h0); end
        #1;
        reset = 1'b0;
        model_reset();
        step(0, 32'h0, 0, 0, 0);
        checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL areset_restart_pcf got=%h exp=%h", PCF, 32'h4); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL areset_restart_pcd got=%h exp=%h", PCD, 32'h0); end
    endtask

    task automatic test_random();
        do_reset();
        salt = $urandom;
        for (int n = 0; n < 300; n++) begin
            logic        src, sf, sd, fl;
            logic [31:0] tgt;
            src = ($urandom_range(0, 3) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 1) == 1) tgt = {tgt[31:2], 2'b00};
            sf  = ($urandom_range(0, 4) == 0);
            sd  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 5) == 0);
            step(src, tgt, sf, sd, fl);
            if ($urandom_range(0, 40) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                reset = 1'b0;
                model_reset();
            end
            checks++; if (PCF !== m_pc) begin errors++; $display("FAIL rnd_pcf[%0d] got=%h exp=%h", n, PCF, m_pc); end
            checks++; if (PCPlus4F !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4f[%0d] got=%h exp=%h", n, PCPlus4F, m_pc + 32'd4); end
            checks++; if (InstrD !== m_instr_d) begin errors++; $display("FAIL rnd_instrd[%0d] got=%h exp=%h", n, InstrD, m_instr_d); end
            checks++; if (PCD !== m_pc_d) begin errors++; $display("FAIL rnd_pcd[%0d] got=%h exp=%h", n, PCD, m_pc_d); end
            checks++; if (PCPlus4D !== m_pc4_d) begin errors++; $display("FAIL rnd_pc4d[%0d] got=%h exp=%h", n, PCPlus4D, m_pc4_d); end
        end
        salt = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        PCSrcE = 0; PCTargetE = 0; StallF = 0; StallD = 0; FlushD = 0;
        model_reset();
        test_reset();
        test_free_run();
        test_redirect();
        test_stall();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_pipe.md
# fetch_pc_pipe

Instruction-fetch datapath of the 5-stage RISC-V pipeline. It holds the program counter, computes PC+4, and selects the next PC from the sequential or redirect target. It also forms the IF/ID pipeline register that hands the fetched instruction and its PC values to decode. Instruction memory is external: the block drives `PCF` to it and receives `InstrF` combinationally in the same cycle.

## Interface
- `WIDTH`, 32: datapath width of the PC and instruction.
- `RESET_PC`, 32'h0000_0000: value loaded into `PCF` on reset.
- `clk`  in  1: rising-edge clock; the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `PCSrcE`  in  1: 1 = redirect the next PC to `PCTargetE` (taken branch or jump from execute).
- `PCTargetE`  in  WIDTH: redirect target address.
- `StallF`  in  1: 1 = hold `PCF`.
- `StallD`  in  1: 1 = hold the IF/ID register.
- `FlushD`  in  1: 1 = clear the IF/ID register on the next edge.
- `InstrF`  in  WIDTH: instruction read from external imem at `PCF`.
- `PCF`  out  WIDTH: current fetch PC (register output).
- `PCPlus4F`  out  WIDTH: `PCF` + 4 (combinational).
- `InstrD`  out  WIDTH: instruction in decode.
- `PCD`  out  WIDTH: PC of `InstrD`.
- `PCPlus4D`  out  WIDTH: `PCD` + 4 as captured.
- Tie `StallF`, `StallD` and `FlushD` to 0 for a plain pipeline with no hazard handling.

## Operation
- **PC+4 adder:** `PCPlus4F` = `PCF` + 4, modulo 2^WIDTH. The carry is discarded, so 32'hFFFF_FFFC + 4 = 0.
- **Next-PC mux:** `PCNext` = `PCSrcE` ? `PCTargetE` : `PCPlus4F`. There is no alignment check; the target is loaded as given.
- **PC register (flopr with enable)**, in priority order:
  - `reset` = 1: `PCF` ← `RESET_PC`.
  - else `StallF` = 1: hold `PCF`. A redirect in that cycle is lost; the hazard unit must not stall F while `PCSrcE` = 1.
  - else: `PCF` ← `PCNext`.
- **IF/ID register**, in priority order:
  - `reset` = 1: `InstrD`, `PCD` and `PCPlus4D` all ← 0.
  - else `FlushD` = 1: all three ← 0. Flush overrides stall.
  - else `StallD` = 1: hold all three.
  - else: `InstrD` ← `InstrF`, `PCD` ← `PCF`, `PCPlus4D` ← `PCPlus4F`.
- No other state exists in the block.

## Timing
- All register updates occur on the rising edge of `clk`. Reset acts immediately, independent of the clock.
- Reset values: `PCF` = `RESET_PC`; `InstrD` = `PCD` = `PCPlus4D` = 0. `PCPlus4F` = `RESET_PC` + 4 combinationally during reset.
- First edge after reset release (no stall or flush): `PCF` = 4, `PCD` = 0, `PCPlus4D` = 4, `InstrD` = mem[0].
- Latency is one cycle from F to D: values on `PCF`/`InstrF` in cycle n appear on `PCD`/`InstrD` in cycle n+1.
- **Redirect:** `PCSrcE` sampled high at edge k makes `PCF` = `PCTargetE` after edge k. The instruction at the old `PCF` still enters D at edge k; squashing it is done with `FlushD`.
- **Simultaneous events:**
  - `FlushD` + `StallD`: flush wins.
  - `StallF` + `PCSrcE`: stall wins.
  - `reset` asserted mid-run: all registers clear asynchronously within the same cycle.

## Test plan
1. **Reset then free-run.** Assert reset, release, apply 5 edges with imem returning 32'h0000_0000+PC.
   - `PCF` sequence: 0, 4, 8, 12, 16, 20.
   - `PCD` lags `PCF` by one cycle.
   - `PCPlus4D` = `PCD` + 4 and `InstrD` = `PCD`.
2. **Redirect.** With `PCF` = 8, set `PCSrcE` = 1 and `PCTargetE` = 32'h40 for one cycle.
   - Next cycle: `PCF` = 32'h40 and `PCD` = 8.
   - The cycle after: `PCD` = 32'h40 and `PCPlus4D` = 32'h44.
3. **Stall.** With `PCF` = 12, assert `StallF` and `StallD` for 2 cycles.
   - `PCF` stays 12 and `PCD` stays 8 throughout.
   - After release, fetch resumes with `PCF` = 16.
4. **Flush priority.** Assert `FlushD` together with `StallD`.
   - Next edge: `InstrD` = `PCD` = `PCPlus4D` = 0.
   - `PCF` advances normally.
5. **Wrap-around.** Redirect to 32'hFFFF_FFFC.
   - `PCPlus4F` = 0 and the next `PCF` = 0.
   - `PCPlus4D` = 0 one cycle later.
6. **Asynchronous reset mid-run.** Pulse reset between edges while `PCF` = 32'h40.
   - All outputs clear immediately, without waiting for an edge.
   - After release, fetch restarts from 0.
